// File: rtl/cmn_list_pkg.sv
// rtl/cmn_list_pkg.sv - shared helpers for the list allocator slice
package cmn_list_pkg;

  localparam int POP_MAX = 256;

  // Callers zero-extend their vector to POP_MAX bits before counting.
  function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 9'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cmn_list_alloc_if.sv
// rtl/cmn_list_alloc_if.sv - allocation/release bus of the free-list allocator
interface cmn_list_alloc_if
  import cmn_list_pkg::*;
#(
  parameter int ENTRY_NUM = 16,
  parameter int REQ_NUM   = 4,
  parameter int REL_NUM   = 4
);
  localparam int AWIDTH = $clog2(ENTRY_NUM);
  localparam int CWIDTH = $clog2(ENTRY_NUM + 1);

  logic [REQ_NUM-1:0]                 v_alloc_req;
  logic [REQ_NUM-1:0]                 v_alloc_gnt;
  logic [REQ_NUM-1:0][ENTRY_NUM-1:0]  v_alloc_oh;
  logic [REQ_NUM-1:0][AWIDTH-1:0]     v_alloc_bin;
  logic [REL_NUM-1:0]                 v_rel_vld;
  logic [REL_NUM-1:0][AWIDTH-1:0]     v_rel_bin;
  logic                               flush;
  logic [CWIDTH-1:0]                  free_cnt;
  logic                               none_free;
  logic                               err_dbl_rel;

  modport master (
    output v_alloc_req, v_rel_vld, v_rel_bin, flush,
    input  v_alloc_gnt, v_alloc_oh, v_alloc_bin, free_cnt, none_free, err_dbl_rel
  );

  modport slave (
    input  v_alloc_req, v_rel_vld, v_rel_bin, flush,
    output v_alloc_gnt, v_alloc_oh, v_alloc_bin, free_cnt, none_free, err_dbl_rel
  );

endinterface

// File: rtl/cmn_onehot2bin.sv
// rtl/cmn_onehot2bin.sv - one-hot to binary index encoder (zero for an all-zero input)
module cmn_onehot2bin #(
  parameter int WIDTH  = 16,
  parameter int BWIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  oh,
  output logic [BWIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) bin = bin | BWIDTH'(i);
    end
  end

endmodule

// File: rtl/cmn_rr_lead_one.sv
// rtl/cmn_rr_lead_one.sv - picks the first PICK_NUM set bits in search order from start
module cmn_rr_lead_one
  import cmn_list_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PICK_NUM = 4,
  parameter int AWIDTH   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]                vec,
  input  logic [AWIDTH-1:0]               start,
  output logic [PICK_NUM-1:0][WIDTH-1:0]  pick_oh,
  output logic [PICK_NUM-1:0]             pick_vld
);

  // Rotate so start sits at bit 0, peel lowest set bits, rotate each pick back.
  always_comb begin
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   low;
    pick_oh  = '0;
    pick_vld = '0;
    dbl      = {vec, vec} >> start;
    rem      = dbl[WIDTH-1:0];
    for (int i = 0; i < PICK_NUM; i++) begin
      low         = rem & (~rem + 1'b1);
      rem         = rem & ~low;
      dbl         = {low, low} << start;
      pick_oh[i]  = dbl[2*WIDTH-1:WIDTH];
      pick_vld[i] = |low;
    end
  end

endmodule

// File: rtl/cmn_list_alloc.sv
// rtl/cmn_list_alloc.sv - multi-port free-list allocator owning a registered free bitmap
module cmn_list_alloc
  import cmn_list_pkg::*;
#(
  parameter int ENTRY_NUM = 16,
  parameter int REQ_NUM   = 4,
  parameter int REL_NUM   = 4,
  parameter int ROTATE    = 0
) (
  input  logic           clk,
  input  logic           rst,
  cmn_list_alloc_if.slave bus
);
  localparam int AWIDTH = $clog2(ENTRY_NUM);
  localparam int CWIDTH = $clog2(ENTRY_NUM + 1);

  logic [ENTRY_NUM-1:0]               bitmap_q, bitmap_next, gnt_mask, rel_mask;
  logic [AWIDTH-1:0]                  rr_ptr_q, rr_ptr_next, start;
  logic [CWIDTH-1:0]                  free_cnt_q, free_cnt_next;
  logic                               err_q, err_next;
  logic [REQ_NUM-1:0][ENTRY_NUM-1:0]  pick_oh, alloc_oh;
  logic [REQ_NUM-1:0][AWIDTH-1:0]     alloc_bin;
  logic [REQ_NUM-1:0]                 pick_vld, gnt;

  assign start = (ROTATE != 0) ? rr_ptr_q : '0;

  cmn_rr_lead_one #(.WIDTH(ENTRY_NUM), .PICK_NUM(REQ_NUM), .AWIDTH(AWIDTH)) u_pick (
    .vec      (bitmap_q),
    .start    (start),
    .pick_oh  (pick_oh),
    .pick_vld (pick_vld)
  );

  // Grants see only registered state, so releases never reach them combinationally.
  for (genvar g = 0; g < REQ_NUM; g++) begin : g_chan
    assign gnt[g]      = bus.v_alloc_req[g] & pick_vld[g] & ~bus.flush;
    assign alloc_oh[g] = gnt[g] ? pick_oh[g] : '0;
    cmn_onehot2bin #(.WIDTH(ENTRY_NUM), .BWIDTH(AWIDTH)) u_bin (
      .oh  (alloc_oh[g]),
      .bin (alloc_bin[g])
    );
  end

  assign bus.v_alloc_gnt = gnt;
  assign bus.v_alloc_oh  = alloc_oh;
  assign bus.v_alloc_bin = alloc_bin;
  assign bus.free_cnt    = free_cnt_q;
  assign bus.none_free   = (free_cnt_q == '0);
  assign bus.err_dbl_rel = err_q;

  // A release is legal only for an in-range, currently allocated entry named once this cycle.
  always_comb begin
    rel_mask = '0;
    err_next = 1'b0;
    for (int c = 0; c < REL_NUM; c++) begin
      if (bus.v_rel_vld[c]) begin
        if (32'(bus.v_rel_bin[c]) >= ENTRY_NUM) begin
          err_next = 1'b1;
        end else if (bitmap_q[bus.v_rel_bin[c]] || rel_mask[bus.v_rel_bin[c]]) begin
          err_next = 1'b1;
        end else begin
          rel_mask[bus.v_rel_bin[c]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_mask    = '0;
    rr_ptr_next = rr_ptr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      gnt_mask = gnt_mask | alloc_oh[i];
      if (gnt[i] && ROTATE != 0) begin
        rr_ptr_next = (alloc_bin[i] == AWIDTH'(ENTRY_NUM - 1)) ? '0 : alloc_bin[i] + 1'b1;
      end
    end
    bitmap_next   = (bitmap_q & ~gnt_mask) | rel_mask;
    free_cnt_next = free_cnt_q - CWIDTH'(popcount(POP_MAX'(gnt)))
                               + CWIDTH'(popcount(POP_MAX'(rel_mask)));
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bitmap_q   <= '1;
      rr_ptr_q   <= '0;
      free_cnt_q <= CWIDTH'(ENTRY_NUM);
      err_q      <= 1'b0;
    end else begin
      bitmap_q   <= bitmap_next;
      rr_ptr_q   <= rr_ptr_next;
      free_cnt_q <= free_cnt_next;
      err_q      <= err_next;
    end
  end

endmodule

// File: tb/tb_cmn_list_alloc.sv
// tb/tb_cmn_list_alloc.sv - randomized scoreboard bench for both search orders of cmn_list_alloc
module tb_cmn_list_alloc;
  localparam int EN = 8;
  localparam int RQ = 2;
  localparam int RL = 2;

  typedef struct packed {
    logic [1:0]      gnt;
    logic [1:0][7:0] oh;
    logic [1:0][2:0] bin;
    logic [3:0]      cnt;
    logic            nf;
    logic            err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmn_list_alloc_if #(.ENTRY_NUM(EN), .REQ_NUM(RQ), .REL_NUM(RL)) bus0 ();
  cmn_list_alloc_if #(.ENTRY_NUM(EN), .REQ_NUM(RQ), .REL_NUM(RL)) bus1 ();

  cmn_list_alloc #(.ENTRY_NUM(EN), .REQ_NUM(RQ), .REL_NUM(RL), .ROTATE(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  cmn_list_alloc #(.ENTRY_NUM(EN), .REQ_NUM(RQ), .REL_NUM(RL), .ROTATE(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: list of free flags, search pointer, pending error flag.
  bit   free_tab [2][EN];
  int   ptr_m [2];
  bit   err_m [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < EN; k++) free_tab[d][k] = 1'b1;
      ptr_m[d] = 0;
      err_m[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [1:0] req, input logic [1:0] rv,
                            input int rb0, input int rb1, input logic fl, input logic r,
                            output obs_t e);
    int free_list[$];
    int cnt;
    int rb[2];
    bit pre[EN];
    bit seen[EN];
    e   = '0;
    cnt = 0;
    for (int k = 0; k < EN; k++) if (free_tab[d][k]) cnt++;
    e.cnt = 4'(cnt);
    e.nf  = (cnt == 0);
    e.err = err_m[d];
    for (int k = 0; k < EN; k++) begin
      int idx;
      idx = ((d == 1 ? ptr_m[d] : 0) + k) % EN;
      if (free_tab[d][idx]) free_list.push_back(idx);
    end
    for (int i = 0; i < RQ; i++) begin
      if (req[i] && !fl && i < free_list.size()) begin
        e.gnt[i] = 1'b1;
        e.bin[i] = 3'(free_list[i]);
        e.oh[i]  = 8'(1) << free_list[i];
      end
    end
    if (r || fl) begin
      for (int k = 0; k < EN; k++) free_tab[d][k] = 1'b1;
      ptr_m[d] = 0;
      err_m[d] = 1'b0;
    end else begin
      for (int k = 0; k < EN; k++) begin
        pre[k]  = free_tab[d][k];
        seen[k] = 1'b0;
      end
      for (int i = 0; i < RQ; i++) begin
        if (e.gnt[i]) begin
          free_tab[d][free_list[i]] = 1'b0;
          if (d == 1) ptr_m[d] = (free_list[i] + 1) % EN;
        end
      end
      err_m[d] = 1'b0;
      rb[0] = rb0;
      rb[1] = rb1;
      for (int c = 0; c < RL; c++) begin
        if (rv[c]) begin
          if (rb[c] >= EN || pre[rb[c]] || seen[rb[c]]) err_m[d] = 1'b1;
          else begin
            free_tab[d][rb[c]] = 1'b1;
            seen[rb[c]] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] rv, input int rb0,
                       input int rb1, input logic fl, input logic r);
    obs_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus0.v_alloc_req = req;  bus1.v_alloc_req = req;
    bus0.v_rel_vld   = rv;   bus1.v_rel_vld   = rv;
    bus0.v_rel_bin   = {3'(rb1), 3'(rb0)};
    bus1.v_rel_bin   = {3'(rb1), 3'(rb0)};
    bus0.flush       = fl;   bus1.flush       = fl;
    model_step(0, req, rv, rb0, rb1, fl, r, e);
    exp_q0.push_back(e);
    model_step(1, req, rv, rb0, rb1, fl, r, e);
    exp_q1.push_back(e);
  endtask

  task automatic check(input int d, input obs_t e, input obs_t a);
    vectors++;
    if (a.gnt !== e.gnt) begin
      miscompares++;
      $display("FAIL dut%0d gnt got %b want %b", d, a.gnt, e.gnt);
    end
    vectors++;
    if (a.bin !== e.bin) begin
      miscompares++;
      $display("FAIL dut%0d bin got %h want %h", d, a.bin, e.bin);
    end
    vectors++;
    if (a.oh !== e.oh) begin
      miscompares++;
      $display("FAIL dut%0d oh got %h want %h", d, a.oh, e.oh);
    end
    vectors++;
    if (a.cnt !== e.cnt || a.nf !== e.nf) begin
      miscompares++;
      $display("FAIL dut%0d free_cnt/none_free got %0d/%b want %0d/%b", d, a.cnt, a.nf, e.cnt, e.nf);
    end
    vectors++;
    if (a.err !== e.err) begin
      miscompares++;
      $display("FAIL dut%0d err_dbl_rel got %b want %b", d, a.err, e.err);
    end
  endtask

  initial begin
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        a = {bus0.v_alloc_gnt, bus0.v_alloc_oh, bus0.v_alloc_bin, bus0.free_cnt,
             bus0.none_free, bus0.err_dbl_rel};
        check(0, exp_q0.pop_front(), a);
      end
      if (exp_q1.size() > 0) begin
        a = {bus1.v_alloc_gnt, bus1.v_alloc_oh, bus1.v_alloc_bin, bus1.free_cnt,
             bus1.none_free, bus1.err_dbl_rel};
        check(1, exp_q1.pop_front(), a);
      end
    end
  end

  initial begin
    logic [1:0] req;
    logic [1:0] rv;
    int         rb0, rb1, hi;
    bus0.v_alloc_req = '0;  bus1.v_alloc_req = '0;
    bus0.v_rel_vld   = '0;  bus1.v_rel_vld   = '0;
    bus0.v_rel_bin   = '0;  bus1.v_rel_bin   = '0;
    bus0.flush       = 1'b0; bus1.flush      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    drive(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
    drive(2'b10, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
    repeat (5) drive(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b11, 2'b01, 5, 0, 1'b0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b1, 1'b0);
    drive(2'b00, 2'b01, 3, 0, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    drive(2'b11, 2'b11, 4, 4, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      hi  = ((n / 40) % 2 == 1) ? 70 : 15;
      req = 2'($urandom);
      rv[0] = ($urandom_range(0, 99) < hi);
      rv[1] = ($urandom_range(0, 99) < hi);
      rb0 = int'($urandom_range(0, EN - 1));
      rb1 = ($urandom_range(0, 9) == 0) ? rb0 : int'($urandom_range(0, EN - 1));
      drive(req, rv, rb0, rb1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end
    drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain left %0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
